// File: rtl/bitshift_seq_ctrl.sv
// Loads a parallel word into a serial-in shift register one bit per cycle, reads it back and checks it.
// Result appears WIDTH+3 cycles after accept; in_ready only in IDLE, HOLD stalls until out_ready.
module bitshift_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_clr,
  output logic             sr_en,
  output logic             sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  word_r;
  logic [WIDTH-1:0]  shift_r;
  logic [WIDTH-1:0]  exp_w;
  logic [CW-1:0]     cnt;
  logic              mis_now;

  // Contents the register must hold once every bit has been shifted in;
  // feeding exp_w MSB-first produces exactly this pattern for both orders.
  always_comb begin
    exp_w = word_r;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        exp_w[i] = word_r[WIDTH-1-i];
      end
    end
  end

  assign mis_now = (sr_q != exp_w);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sr_clr    = 1'b0;
    sr_en     = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        sr_clr    = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sr_en = 1'b1;
        if (cnt == LAST) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Reset also clears the external register and must never overlap a shift.
    if (rst) begin
      sr_clr = 1'b1;
      sr_en  = 1'b0;
    end
  end

  assign sr_d = sr_en & shift_r[WIDTH-1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_r   <= '0;
      shift_r  <= '0;
      cnt      <= '0;
      out_data <= '0;
      mismatch <= 1'b0;
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) word_r <= in_data;
        end
        CLEAR: begin
          shift_r <= exp_w;
          cnt     <= '0;
        end
        SHIFT: begin
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
        end
        CHECK: begin
          out_data <= sr_q;
          mismatch <= mis_now;
          if (word_cnt != {CNT_W{1'b1}}) word_cnt <= word_cnt + 1'b1;
          if (mis_now && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitshift_seq_ctrl.sv
// Three controllers (MSB-first, LSB-first, 2-bit counters) driven in lockstep, each with its own shift register model.
module tb_bitshift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       frc;
  logic [3:0] in_data;

  logic [2:0] in_ready_v, sr_clr_v, sr_en_v, sr_d_v, out_valid_v, mismatch_v, busy_v;
  logic [3:0] sr_q_v     [3];
  logic [3:0] out_data_v [3];
  logic [3:0] sr_reg     [3];
  logic [7:0] wc_v       [3];
  logic [7:0] ec_v       [3];
  logic [7:0] wc_a, ec_a, wc_b, ec_b;
  logic [1:0] wc_c, ec_c;

  always #5 clk = ~clk;

  bitshift_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
    .sr_clr(sr_clr_v[0]), .sr_en(sr_en_v[0]), .sr_d(sr_d_v[0]), .sr_q(sr_q_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .mismatch(mismatch_v[0]), .busy(busy_v[0]), .word_cnt(wc_a), .err_cnt(ec_a)
  );

  bitshift_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
    .sr_clr(sr_clr_v[1]), .sr_en(sr_en_v[1]), .sr_d(sr_d_v[1]), .sr_q(sr_q_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .mismatch(mismatch_v[1]), .busy(busy_v[1]), .word_cnt(wc_b), .err_cnt(ec_b)
  );

  bitshift_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_data(in_data),
    .sr_clr(sr_clr_v[2]), .sr_en(sr_en_v[2]), .sr_d(sr_d_v[2]), .sr_q(sr_q_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2]),
    .mismatch(mismatch_v[2]), .busy(busy_v[2]), .word_cnt(wc_c), .err_cnt(ec_c)
  );

  assign wc_v[0] = wc_a;
  assign ec_v[0] = ec_a;
  assign wc_v[1] = wc_b;
  assign ec_v[1] = ec_b;
  assign wc_v[2] = {6'b0, wc_c};
  assign ec_v[2] = {6'b0, ec_c};

  // Serial-in shift register models; frc overrides the read-back to zero.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sr_clr_v[i]) sr_reg[i] <= 4'h0;
      else if (sr_en_v[i]) sr_reg[i] <= {sr_reg[i][2:0], sr_d_v[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) sr_q_v[i] = frc ? 4'h0 : sr_reg[i];
  end

  typedef struct packed {
    logic [2:0][3:0] data;
    logic [2:0]      mis;
    logic [2:0][3:0] seq;
    logic [2:0][7:0] wc;
    logic [2:0][7:0] ec;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   excl_viol = 0;
  int   d_viol = 0;
  int   wc_m[3];
  int   ec_m[3];
  int   cmax[3] = '{255, 255, 3};
  logic [3:0] rec[3];
  int   nen[3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: records the serial stream and compares results on the output handshake.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        rec[i] = 4'h0;
        nen[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sr_en_v[i] && sr_clr_v[i]) excl_viol++;
        if (!sr_en_v[i] && sr_d_v[i]) d_viol++;
        if (sr_en_v[i]) begin
          rec[i] = {rec[i][2:0], sr_d_v[i]};
          nen[i]++;
        end
      end
      if (out_valid_v[0]) begin
        if (sbq.size() == 0) begin
          check_eq("spurious_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
        end else if (!out_ready) begin
          check_eq("hold_data", {28'b0, out_data_v[0]}, {28'b0, sbq[0].data[0]});
        end else begin
          exp_t e;
          e = sbq.pop_front();
          for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("out_valid%0d", i), {31'b0, out_valid_v[i]}, 32'd1);
            check_eq($sformatf("out_data%0d", i), {28'b0, out_data_v[i]}, {28'b0, e.data[i]});
            check_eq($sformatf("mismatch%0d", i), {31'b0, mismatch_v[i]}, {31'b0, e.mis[i]});
            check_eq($sformatf("sr_d_seq%0d", i), {28'b0, rec[i]}, {28'b0, e.seq[i]});
            check_eq($sformatf("sr_en_cycles%0d", i), nen[i], 32'd4);
            check_eq($sformatf("word_cnt%0d", i), {24'b0, wc_v[i]}, {24'b0, e.wc[i]});
            check_eq($sformatf("err_cnt%0d", i), {24'b0, ec_v[i]}, {24'b0, e.ec[i]});
            rec[i] = 4'h0;
            nen[i] = 0;
          end
        end
      end
    end
  end

  // Call between clock edges; returns at the first negedge showing out_valid.
  task automatic send_word(input logic [3:0] w, input logic force_zero);
    exp_t e;
    logic [3:0] rv;
    int lat;
    int n;
    frc      = force_zero;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready_v[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", {31'b0, in_ready_v[0]}, 32'd1);
    for (int i = 0; i < 4; i++) rv[i] = w[3-i];
    e.seq[0] = w;
    e.seq[1] = rv;
    e.seq[2] = w;
    for (int i = 0; i < 3; i++) begin
      e.data[i] = force_zero ? 4'h0 : e.seq[i];
      e.mis[i]  = force_zero && (e.seq[i] != 4'h0);
      if (wc_m[i] < cmax[i]) wc_m[i]++;
      if (e.mis[i] && ec_m[i] < cmax[i]) ec_m[i]++;
      e.wc[i] = wc_m[i][7:0];
      e.ec[i] = ec_m[i][7:0];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", lat, 32'd7);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      if (!busy_v[0] && !out_valid_v[0]) break;
      @(negedge clk);
    end
    check_eq("idle", {31'b0, busy_v[0]}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    frc       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wc_m[i] = 0;
      ec_m[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sr_clr", {29'b0, sr_clr_v}, 32'h7);
    check_eq("rst_sr_en", {29'b0, sr_en_v}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_in_ready%0d", i), {31'b0, in_ready_v[i]}, 32'd1);
      check_eq($sformatf("rst_busy%0d", i), {31'b0, busy_v[i]}, 32'd0);
      check_eq($sformatf("rst_out_valid%0d", i), {31'b0, out_valid_v[i]}, 32'd0);
      check_eq($sformatf("rst_out_data%0d", i), {28'b0, out_data_v[i]}, 32'd0);
      check_eq($sformatf("rst_mismatch%0d", i), {31'b0, mismatch_v[i]}, 32'd0);
      check_eq($sformatf("rst_word_cnt%0d", i), {24'b0, wc_v[i]}, 32'd0);
      check_eq($sformatf("rst_err_cnt%0d", i), {24'b0, ec_v[i]}, 32'd0);
      check_eq($sformatf("rst_sr_d%0d", i), {31'b0, sr_d_v[i]}, 32'd0);
    end

    send_word(4'hD, 1'b0); wait_idle();
    send_word(4'h3, 1'b0); wait_idle();
    send_word(4'h9, 1'b1); wait_idle();
    send_word(4'h5, 1'b0); wait_idle();

    // Stalled consumer: result held, next word blocked until after the handshake.
    out_ready = 1'b0;
    send_word(4'hA, 1'b0);
    in_data  = 4'h6;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("hold_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
      check_eq("hold_out_valid", {31'b0, out_valid_v[0]}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("no_early_accept", {31'b0, in_ready_v[0]}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("post_hs_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    check_eq("post_hs_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    send_word(4'h6, 1'b0); wait_idle();

    for (int r = 0; r < 3; r++) begin
      send_word(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    // Reset during the second shift cycle aborts the word.
    frc      = 1'b0;
    in_data  = 4'h5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("abort_sr_clr", {31'b0, sr_clr_v[0]}, 32'd1);
    check_eq("abort_sr_en", {31'b0, sr_en_v[0]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wc_m[i] = 0;
      ec_m[i] = 0;
    end
    check_eq("abort_busy", {31'b0, busy_v[0]}, 32'd0);
    check_eq("abort_sr_en_after", {31'b0, sr_en_v[0]}, 32'd0);
    check_eq("abort_word_cnt", {24'b0, wc_v[0]}, 32'd0);
    repeat (10) begin
      @(negedge clk);
      check_eq("abort_no_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    end

    send_word(4'hB, 1'b0); wait_idle();
    send_word(4'h1, 1'b1); wait_idle();
    send_word(4'h2, 1'b1); wait_idle();
    send_word(4'h4, 1'b1); wait_idle();
    send_word(4'h8, 1'b1); wait_idle();
    send_word(4'hF, 1'b1); wait_idle();
    check_eq("sat_word_cnt", {30'b0, wc_c}, 32'd3);
    check_eq("sat_err_cnt", {30'b0, ec_c}, 32'd3);
    check_eq("a_word_cnt", {24'b0, wc_a}, 32'd6);
    check_eq("a_err_cnt", {24'b0, ec_a}, 32'd5);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", sbq.size(), 32'd0);
    check_eq("sr_clr_en_excl", excl_viol, 32'd0);
    check_eq("sr_d_outside_shift", d_viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
